// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC and the fetch
// state encoding used by fetch_unit.
package cpu_pkg;

   localparam int          DEF_ADDR_W   = 32;
   localparam int          DEF_INSTR_W  = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          PC_STEP      = 4;

   typedef enum logic {
      ST_FETCH  = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue holding fetched words with their PCs; head is
// presented combinationally and reads as zero while the queue is empty.
module fetch_queue #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic [ADDR_W-1:0] push_pc_i,
   input  logic              pop_i,
   output logic              empty_o,
   output logic [1:0]        count_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic [ADDR_W-1:0] head_pc_o
);

   logic [DATA_W-1:0] data_q [2];
   logic [ADDR_W-1:0] pc_q   [2];
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [1:0]        count_q;

   always_ff @(posedge clk) begin
      if (!reset || flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) wr_ptr_q <= ~wr_ptr_q;
         if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   // NOTE: storage needs no reset; the pointers and count decide what is visible.
   always_ff @(posedge clk) begin
      if (push_i) begin
         data_q[wr_ptr_q] <= push_data_i;
         pc_q[wr_ptr_q]   <= push_pc_i;
      end
   end

   assign empty_o     = (count_q == 2'd0);
   assign count_o     = count_q;
   assign head_data_o = empty_o ? '0 : data_q[rd_ptr_q];
   assign head_pc_o   = empty_o ? '0 : pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues imem reads, queues responses for the core and
// handles redirect/halt. Define FETCH_COUNT_EN to build the delivered-instruction counter.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSTR_W  = DEF_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt,
   output logic [31:0]        fetch_count
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q;
   logic [ADDR_W-1:0] inflight_pc_q;

   logic              q_empty;
   logic [1:0]        q_count;
   logic              handshake;
   logic              push;
   logic [2:0]        budget;

   // A pop this cycle frees a slot, which keeps the stream at one word per cycle.
   assign budget    = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, handshake};
   assign imem_req  = reset && (state_q == ST_FETCH) && !halt && !redirect_valid
                      && (budget < 3'd2);
   assign imem_addr = pc_q;

   assign instr_valid = !q_empty && !redirect_valid;
   assign handshake   = instr_valid && instr_ready;
   assign push        = inflight_q && !redirect_valid;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (imem_req)  pc_d = pc_q + ADDR_W'(PC_STEP);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= imem_req;
         inflight_pc_q <= pc_q;
         if (redirect_valid)
            state_q <= ST_FETCH;
         else if (state_q == ST_FETCH && halt)
            state_q <= ST_HALTED;
      end
   end

   fetch_queue #(
      .DATA_W (INSTR_W),
      .ADDR_W (ADDR_W)
   ) u_queue (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (imem_rdata),
      .push_pc_i   (inflight_pc_q),
      .pop_i       (handshake),
      .empty_o     (q_empty),
      .count_o     (q_count),
      .head_data_o (instr_data),
      .head_pc_o   (instr_pc)
   );

`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_count_q;

   always_ff @(posedge clk) begin
      if (!reset)         fetch_count_q <= 32'd0;
      else if (handshake) fetch_count_q <= fetch_count_q + 32'd1;
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 32'd0;
`endif

endmodule
